alarm_controller: RTL and testbench
===================================

# alarm_controller

Sequencer for the seven-slot alarm comparator bank. It owns the seven 13-bit alarm registers that feed the comparators. It loads them through a valid/ready write port and masks disabled slots with a never-matching sentinel. It also runs the ring/snooze/acknowledge state machine, triggered by the comparator bank's any-match flag `AA`.

## Interface
Parameters:
- `SNOOZE_MIN`, default 5: minutes spent in SNOOZE before ringing again; range 1–255.
- `RING_MIN`, default 10: minutes of RING before auto-off; range 1–255; used only with `ALARM_AUTO_OFF_EN`.
- `MAX_SNOOZE`, default 3: snoozes allowed per alarm event; range 0–255.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `AA`  in  1: any-match flag from the comparator bank; level, combinational from `CT` and `Q_r*`.
- `min_tick`  in  1: one-cycle pulse, once per minute.
- `wr_valid`  in  1: write request.
- `wr_ready`  out  1: write may be accepted this cycle.
- `wr_idx`  in  3: slot index 0–6; 7 = no slot.
- `wr_time`  in  13: alarm time code.
- `wr_en`  in  1: slot enable value to store.
- `ack`  in  1: user stop, level sampled each cycle.
- `snooze_btn`  in  1: user snooze, level sampled each cycle.
- `Q_r0`…`Q_r6`  out  13 each: alarm words driven to the comparators.
- `ring`  out  1: buzzer drive.
- `state`  out  2: IDLE=0, RING=1, SNOOZE=2, HOLD=3.

## Operation
- **Storage**
  - Per slot: `time[12:0]` and `en`.
  - `Q_rN = en[N] ? time[N] : 13'h1FFF`. The time counter never produces `13'h1FFF`.
- **Write port**
  - `wr_ready = !rst && state != RING`.
  - A write is accepted when `wr_valid && wr_ready`. The slot is updated at that edge.
  - `wr_idx == 7`: accepted and discarded.
  - Writes in IDLE, SNOOZE and HOLD are all legal.
- **Edge detect**
  - `aa_q` is a registered copy of `AA`.
  - `rise = AA && !aa_q`.
- **IDLE** (`ring = 0`)
  - `rise` → RING. Clear `ring_cnt` and `snz_used`.
- **RING** (`ring = 1`)
  - Priority 1: `ack` → HOLD.
  - Priority 2: `snooze_btn && snz_used < MAX_SNOOZE` → SNOOZE. Clear `snz_cnt`; `snz_used++`.
  - `snooze_btn` with `snz_used == MAX_SNOOZE`: ignored.
  - Each `min_tick` increments `ring_cnt`. Auto-off is described under Configuration.
- **SNOOZE** (`ring = 0`)
  - `ack` → HOLD.
  - Each `min_tick` increments `snz_cnt`. When `snz_cnt` would reach `SNOOZE_MIN` → RING, clear `ring_cnt`.
- **HOLD** (`ring = 0`)
  - Stays until `AA == 0`, then → IDLE. This prevents re-triggering within the same matching minute.
- **Rises outside IDLE**
  - `AA` rises in RING, SNOOZE or HOLD are ignored. A second slot matching during an event does not restart it.
- **Counters**
  - 8-bit, saturating, never wrap.
  - A `min_tick` in the same cycle as a state-changing event is consumed by the transition; the new state's counter starts at 0.

## Timing
- **Reset values**
  - All `en = 0`, all `time = 0`, so every `Q_rN = 13'h1FFF`.
  - `ring = 0`, `state = 0`, `wr_ready = 0` while `rst` is high.
  - `aa_q = 1`, so a match already present when reset deasserts does not ring.
- **Write latency**
  - Accept at edge N: `Q_rN` is valid after edge N.
  - `AA` may respond combinationally in cycle N+1.
  - `rise` is seen at edge N+1, with `ring = 1` after edge N+1.
- **Match latency:** `AA` high at edge N with `aa_q` low: `state`/`ring` update after edge N, one cycle.
- **User inputs and ticks:** `ack`, `snooze_btn` and `min_tick` act at the edge where sampled high; outputs change after that edge.
- **Mid-operation reset:** `rst` high at any edge returns every register to its reset value in one cycle. This includes slot contents.

## Configuration
- **`ALARM_AUTO_OFF_EN` defined:** in RING, when `ring_cnt` would reach `RING_MIN` on a `min_tick` → HOLD, `ring = 0`. `ack` and `snooze_btn` in the same cycle take priority.
- **Not defined:** RING persists until `ack` or snooze. `RING_MIN` and `ring_cnt` are unused and removed.

## Test plan
- **Reset:** `rst = 1` for 2 cycles → all `Q_rN = 13'h1FFF`, `ring = 0`, `state = 0`, `wr_ready = 0`; `wr_ready = 1` the cycle after release.
- **Write:** idx 2, time `13'h0A1E`, `wr_en = 1` → `Q_r2 = 13'h0A1E` next cycle. Then idx 7 → no `Q_r*` change. Then idx 2 with `wr_en = 0` → `Q_r2 = 13'h1FFF`.
- **Match/ack:** `AA` 0→1 in IDLE → `ring = 1`, `state = 1` one edge later. `ack` → `state = 3`. `AA` held high 20 cycles → stays 3. `AA = 0` → `state = 0`.
- **Snooze:** `SNOOZE_MIN = 5`, `MAX_SNOOZE = 3` → each snooze returns to RING on the 5th `min_tick`. 4th `snooze_btn` ignored, `ring` stays 1. `wr_ready = 0` throughout RING.
- **Auto-off (`ALARM_AUTO_OFF_EN`, `RING_MIN = 10`):** 10th `min_tick` in RING → `state = 3`, `ring = 0`. Without the macro → still RING after 20 ticks.
- **Simultaneous events and reset:** `ack` with `snooze_btn` → HOLD. `AA` high through reset release → no ring. `rst` mid-SNOOZE → IDLE and all slots sentinel.

Source files
------------

// File: rtl/alarm_controller.sv
// alarm_controller
//   Sequencer for the seven-slot alarm comparator bank. Holds the seven alarm
//   words (time + enable) feeding the comparators, loads them through a
//   valid/ready write port, and runs the IDLE/RING/SNOOZE/HOLD state machine
//   triggered by rising edges of the comparator any-match flag AA.
//
//   Optional feature macro: ALARM_AUTO_OFF_EN
//     defined   -> RING auto-exits to HOLD after RING_MIN minute ticks
//     undefined -> RING persists until ack or snooze (ring counter removed)
//
// Ports
//   clk, rst            : single clock, synchronous active-high reset
//   AA                  : comparator any-match level
//   min_tick            : one-cycle pulse per minute
//   wr_valid/wr_ready   : write handshake; wr_idx (7 = discard), wr_time, wr_en
//   ack, snooze_btn     : user buttons, level sampled every cycle
//   Q_r0..Q_r6          : alarm words (13'h1FFF when slot disabled)
//   ring                : buzzer drive (registered)
//   state               : IDLE=0, RING=1, SNOOZE=2, HOLD=3 (registered)
module alarm_controller #(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_MIN   = 10,
  parameter int MAX_SNOOZE = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        AA,
  input  logic        min_tick,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [2:0]  wr_idx,
  input  logic [12:0] wr_time,
  input  logic        wr_en,
  input  logic        ack,
  input  logic        snooze_btn,
  output logic [12:0] Q_r0,
  output logic [12:0] Q_r1,
  output logic [12:0] Q_r2,
  output logic [12:0] Q_r3,
  output logic [12:0] Q_r4,
  output logic [12:0] Q_r5,
  output logic [12:0] Q_r6,
  output logic        ring,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam logic [12:0] SENTINEL  = 13'h1FFF;
  localparam logic [7:0]  SNOOZE_LIM = 8'(SNOOZE_MIN);
  localparam logic [7:0]  SNZ_MAX    = 8'(MAX_SNOOZE);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [12:0] slot_time_q [7];
  logic [12:0] slot_time_d [7];
  logic        slot_en_q   [7];
  logic        slot_en_d   [7];
  state_t      state_q, state_d;
  logic        ring_q, ring_d;
  logic        aa_q, aa_d;
  logic [7:0]  snz_cnt_q, snz_cnt_d;
  logic [7:0]  snz_used_q, snz_used_d;
  logic        rise;
  logic [12:0] q_r [7];

`ifdef ALARM_AUTO_OFF_EN
  localparam logic [7:0] RING_LIM = 8'(RING_MIN);
  logic [7:0] ring_cnt_q, ring_cnt_d;
`else
  // RING_MIN has no function without auto-off; tie it off explicitly.
  logic [7:0] unused_ring_min;
  assign unused_ring_min = 8'(RING_MIN);
`endif

  assign wr_ready = !rst && (state_q != ST_RING);
  assign rise     = AA && !aa_q;

  always_comb begin
    slot_time_d = slot_time_q;
    slot_en_d   = slot_en_q;
    state_d     = state_q;
    aa_d        = AA;
    snz_cnt_d   = snz_cnt_q;
    snz_used_d  = snz_used_q;
`ifdef ALARM_AUTO_OFF_EN
    ring_cnt_d  = ring_cnt_q;
`endif

    // Index 7 matches no slot, so such writes are accepted and dropped.
    for (int i = 0; i < 7; i++) begin
      if (wr_valid && wr_ready && (wr_idx == 3'(i))) begin
        slot_time_d[i] = wr_time;
        slot_en_d[i]   = wr_en;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d    = ST_RING;
          snz_used_d = 8'd0;
`ifdef ALARM_AUTO_OFF_EN
          ring_cnt_d = 8'd0;
`endif
        end
      end
      ST_RING: begin
        if (ack) begin
          state_d = ST_HOLD;
        end else if (snooze_btn && (snz_used_q < SNZ_MAX)) begin
          state_d    = ST_SNOOZE;
          snz_cnt_d  = 8'd0;
          snz_used_d = sat_inc(snz_used_q);
        end else if (min_tick) begin
`ifdef ALARM_AUTO_OFF_EN
          if (sat_inc(ring_cnt_q) >= RING_LIM) begin
            state_d = ST_HOLD;
          end else begin
            ring_cnt_d = sat_inc(ring_cnt_q);
          end
`endif
        end
      end
      ST_SNOOZE: begin
        if (ack) begin
          state_d = ST_HOLD;
        end else if (min_tick) begin
          // The tick that completes the snooze is consumed by the transition.
          if (sat_inc(snz_cnt_q) >= SNOOZE_LIM) begin
            state_d = ST_RING;
`ifdef ALARM_AUTO_OFF_EN
            ring_cnt_d = 8'd0;
`endif
          end else begin
            snz_cnt_d = sat_inc(snz_cnt_q);
          end
        end
      end
      default: begin  // ST_HOLD: wait out the matching minute
        if (!AA) state_d = ST_IDLE;
      end
    endcase

    ring_d = (state_d == ST_RING);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 7; i++) begin
        slot_time_q[i] <= 13'd0;
        slot_en_q[i]   <= 1'b0;
      end
      state_q    <= ST_IDLE;
      ring_q     <= 1'b0;
      aa_q       <= 1'b1;  // a match present at reset release must not ring
      snz_cnt_q  <= 8'd0;
      snz_used_q <= 8'd0;
`ifdef ALARM_AUTO_OFF_EN
      ring_cnt_q <= 8'd0;
`endif
    end else begin
      slot_time_q <= slot_time_d;
      slot_en_q   <= slot_en_d;
      state_q     <= state_d;
      ring_q      <= ring_d;
      aa_q        <= aa_d;
      snz_cnt_q   <= snz_cnt_d;
      snz_used_q  <= snz_used_d;
`ifdef ALARM_AUTO_OFF_EN
      ring_cnt_q  <= ring_cnt_d;
`endif
    end
  end

  for (genvar gi = 0; gi < 7; gi++) begin : g_qr
    assign q_r[gi] = slot_en_q[gi] ? slot_time_q[gi] : SENTINEL;
  end

  assign Q_r0  = q_r[0];
  assign Q_r1  = q_r[1];
  assign Q_r2  = q_r[2];
  assign Q_r3  = q_r[3];
  assign Q_r4  = q_r[4];
  assign Q_r5  = q_r[5];
  assign Q_r6  = q_r[6];
  assign ring  = ring_q;
  assign state = state_q;

endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller
//   Directed bench for alarm_controller with default parameters
//   (SNOOZE_MIN=5, RING_MIN=10, MAX_SNOOZE=3). Inputs change and outputs are
//   checked 1 ns after each rising clock edge.
module tb_alarm_controller;

  logic        clk = 1'b0;
  logic        rst, AA, min_tick, wr_valid, wr_en, ack, snooze_btn;
  logic        wr_ready, ring;
  logic [2:0]  wr_idx;
  logic [12:0] wr_time;
  logic [12:0] Q_r0, Q_r1, Q_r2, Q_r3, Q_r4, Q_r5, Q_r6;
  logic [1:0]  state;
  logic [12:0] q_obs [7];

  int n_assert = 0;
  int n_fail   = 0;

  alarm_controller dut (
    .clk(clk), .rst(rst), .AA(AA), .min_tick(min_tick),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx),
    .wr_time(wr_time), .wr_en(wr_en), .ack(ack), .snooze_btn(snooze_btn),
    .Q_r0(Q_r0), .Q_r1(Q_r1), .Q_r2(Q_r2), .Q_r3(Q_r3),
    .Q_r4(Q_r4), .Q_r5(Q_r5), .Q_r6(Q_r6),
    .ring(ring), .state(state)
  );

  always #5 clk = ~clk;

  assign q_obs[0] = Q_r0;
  assign q_obs[1] = Q_r1;
  assign q_obs[2] = Q_r2;
  assign q_obs[3] = Q_r3;
  assign q_obs[4] = Q_r4;
  assign q_obs[5] = Q_r5;
  assign q_obs[6] = Q_r6;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_slots(input string tag, input logic [12:0] e0, e1, e2, e3, e4, e5, e6);
    logic [12:0] e [7];
    e = '{e0, e1, e2, e3, e4, e5, e6};
    for (int i = 0; i < 7; i++) chk($sformatf("%s_q%0d", tag, i), 32'(q_obs[i]), 32'(e[i]));
  endtask

  task automatic do_write(input logic [2:0] idx, input logic [12:0] t, input logic en);
    wr_valid = 1'b1; wr_idx = idx; wr_time = t; wr_en = en;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic tick();
    min_tick = 1'b1;
    step();
    min_tick = 1'b0;
    step();
  endtask

  localparam logic [12:0] S = 13'h1FFF;

  initial begin
    rst = 1'b1; AA = 1'b0; min_tick = 1'b0; wr_valid = 1'b0; wr_en = 1'b0;
    ack = 1'b0; snooze_btn = 1'b0; wr_idx = 3'd0; wr_time = 13'd0;

    // Reset
    step(); step();
    chk_slots("reset", S, S, S, S, S, S, S);
    chk("reset_ring", 32'(ring), 32'd0);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_wr_ready", 32'(wr_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("release_wr_ready", 32'(wr_ready), 32'd1);

    // Writes
    do_write(3'd2, 13'h0A1E, 1'b1);
    chk_slots("wr2", S, S, 13'h0A1E, S, S, S, S);
    do_write(3'd7, 13'h0123, 1'b1);
    chk_slots("wr7", S, S, 13'h0A1E, S, S, S, S);
    do_write(3'd6, 13'h0005, 1'b1);
    chk_slots("wr6", S, S, 13'h0A1E, S, S, S, 13'h0005);
    do_write(3'd2, 13'h0A1E, 1'b0);
    chk_slots("wr2_dis", S, S, S, S, S, S, 13'h0005);

    // Match / ack / hold
    AA = 1'b1; step();
    chk("match_state", 32'(state), 32'd1);
    chk("match_ring", 32'(ring), 32'd1);
    chk("ring_wr_ready", 32'(wr_ready), 32'd0);
    ack = 1'b1; step(); ack = 1'b0;
    chk("ack_state", 32'(state), 32'd3);
    chk("ack_ring", 32'(ring), 32'd0);
    for (int i = 0; i < 20; i++) step();
    chk("hold_state", 32'(state), 32'd3);
    chk("hold_wr_ready", 32'(wr_ready), 32'd1);
    AA = 1'b0; step();
    chk("hold_exit", 32'(state), 32'd0);

    // Snooze cycles
    AA = 1'b1; step();
    chk("snz_ring_start", 32'(state), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      snooze_btn = 1'b1; step(); snooze_btn = 1'b0;
      chk($sformatf("snz%0d_state", k), 32'(state), 32'd2);
      chk($sformatf("snz%0d_ring", k), 32'(ring), 32'd0);
      chk($sformatf("snz%0d_wr_ready", k), 32'(wr_ready), 32'd1);
      for (int t = 1; t <= 4; t++) tick();
      chk($sformatf("snz%0d_after4", k), 32'(state), 32'd2);
      min_tick = 1'b1; step(); min_tick = 1'b0;
      chk($sformatf("snz%0d_5th_state", k), 32'(state), 32'd1);
      chk($sformatf("snz%0d_5th_ring", k), 32'(ring), 32'd1);
      chk($sformatf("snz%0d_5th_wr_ready", k), 32'(wr_ready), 32'd0);
    end
    snooze_btn = 1'b1; step(); snooze_btn = 1'b0;
    chk("snz4_ignored_state", 32'(state), 32'd1);
    chk("snz4_ignored_ring", 32'(ring), 32'd1);

    // Ring duration: auto-off at 10th tick when enabled, else persists
    for (int i = 1; i <= 20; i++) begin
      min_tick = 1'b1; step(); min_tick = 1'b0;
`ifdef ALARM_AUTO_OFF_EN
      if (i == 9)  chk("autooff_tick9", 32'(state), 32'd1);
      if (i == 10) begin
        chk("autooff_tick10_state", 32'(state), 32'd3);
        chk("autooff_tick10_ring", 32'(ring), 32'd0);
      end
`else
      if (i == 20) begin
        chk("noauto_tick20_state", 32'(state), 32'd1);
        chk("noauto_tick20_ring", 32'(ring), 32'd1);
      end
`endif
    end
    ack = 1'b1; step(); ack = 1'b0;
    chk("ring_end_hold", 32'(state), 32'd3);
    AA = 1'b0; step();
    chk("ring_end_idle", 32'(state), 32'd0);

    // ack and snooze together: ack wins
    AA = 1'b1; step();
    chk("simul_ring", 32'(state), 32'd1);
    ack = 1'b1; snooze_btn = 1'b1; step(); ack = 1'b0; snooze_btn = 1'b0;
    chk("simul_state", 32'(state), 32'd3);
    AA = 1'b0; step();
    chk("simul_idle", 32'(state), 32'd0);

    // AA held high through reset release: no ring
    AA = 1'b1; rst = 1'b1; step(); step(); rst = 1'b0; step();
    chk("aa_thru_rst_state", 32'(state), 32'd0);
    chk("aa_thru_rst_ring", 32'(ring), 32'd0);
    AA = 1'b0; step();

    // Reset mid-SNOOZE clears state and slots
    do_write(3'd1, 13'h0100, 1'b1);
    chk_slots("pre_rst", S, 13'h0100, S, S, S, S, S);
    AA = 1'b1; step();
    snooze_btn = 1'b1; step(); snooze_btn = 1'b0;
    chk("mid_snz_state", 32'(state), 32'd2);
    rst = 1'b1; step();
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_ring", 32'(ring), 32'd0);
    chk("mid_rst_wr_ready", 32'(wr_ready), 32'd0);
    chk_slots("mid_rst", S, S, S, S, S, S, S);
    rst = 1'b0; AA = 1'b0; step();
    chk("post_rst_state", 32'(state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
